// File: rtl/key_debounce_if.sv
// Key bank bundle: raw active-low button inputs and the debounced level/pulse outputs.
interface key_debounce_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;

    modport master (
        output key_n,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_n,
        output key_level,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_debounce.sv
// Push-button debouncer: 2-flop synchroniser plus per-key stability FSM with press/release pulses.
// Optional long-press pulse per key is built when KEY_LONGPRESS_EN is defined.
module key_debounce #(
    parameter int NUM_KEYS     = 4,
    parameter int DEBOUNCE_CNT = 1000000,
    parameter int CNT_W        = 20,
    parameter int LONG_CNT     = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    key_debounce_if.slave keys
);
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEBOUNCE_CNT < 2 || LONG_CNT < 1 ||
        (longint'(1) << CNT_W) <= longint'(DEBOUNCE_CNT) ||
        (longint'(1) << CNT_W) <= longint'(LONG_CNT)) begin : g_param_check
        $error("key_debounce: illegal parameter combination");
    end

    logic [NUM_KEYS-1:0] sync_p0;
    logic [NUM_KEYS-1:0] sync_p1;
    logic [NUM_KEYS-1:0] sample;

    // Synchroniser resets to released so no phantom press appears after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= keys.key_n;
            sync_p1 <= sync_p0;
        end
    end

    assign sample = ~sync_p1;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        logic [1:0]       state;
        logic [CNT_W-1:0] cnt;
        logic             level_r;
        logic             press_r;
        logic             rel_r;
        logic             accept_press;
        logic             accept_release;

        assign accept_press   = (state == ST_PRESS_WAIT)   &&  sample[k] && (cnt == CNT_LAST);
        assign accept_release = (state == ST_RELEASE_WAIT) && !sample[k] && (cnt == CNT_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                level_r <= 1'b0;
                press_r <= 1'b0;
                rel_r   <= 1'b0;
            end else begin
                press_r <= 1'b0;
                rel_r   <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (sample[k]) begin
                            state <= ST_PRESS_WAIT;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!sample[k]) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else if (accept_press) begin
                            state   <= ST_HELD;
                            level_r <= 1'b1;
                            press_r <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    ST_HELD: begin
                        if (!sample[k]) begin
                            state <= ST_RELEASE_WAIT;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (sample[k]) begin
                            state <= ST_HELD;
                            cnt   <= '0;
                        end else if (accept_release) begin
                            state   <= ST_IDLE;
                            level_r <= 1'b0;
                            rel_r   <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign keys.key_level[k]   = level_r;
        assign keys.key_press[k]   = press_r;
        assign keys.key_release[k] = rel_r;

`ifdef KEY_LONGPRESS_EN
        localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_CNT);
        localparam logic [CNT_W-1:0] HOLD_FIRE = CNT_W'(LONG_CNT - 1);

        logic [CNT_W-1:0] hold;
        logic             long_r;

        // Saturating at LONG_CNT means the fire value is crossed only once per press,
        // and bounce back into HELD resumes counting from the frozen value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold   <= '0;
                long_r <= 1'b0;
            end else begin
                long_r <= 1'b0;
                if (accept_press || accept_release) begin
                    hold <= '0;
                end else if (state == ST_HELD) begin
                    if (hold != HOLD_MAX) begin
                        hold <= hold + CNT_ONE;
                    end
                    if (hold == HOLD_FIRE) begin
                        long_r <= 1'b1;
                    end
                end
            end
        end

        assign keys.key_long[k] = long_r;
`else
        assign keys.key_long[k] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: a scoreboard of expected pulse events checked by a negedge monitor.
module tb_key_debounce;
    localparam int NK  = 4;
    localparam int DB  = 8;
    localparam int LC  = 20;
    localparam int LAT = DB + 2;
`ifdef KEY_LONGPRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    key_debounce_if #(.NUM_KEYS(NK)) kif ();

    key_debounce #(
        .NUM_KEYS    (NK),
        .DEBOUNCE_CNT(DB),
        .CNT_W       (20),
        .LONG_CNT    (LC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .keys (kif.slave)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       at;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
    } ev_t;

    ev_t sb[$];
    int nchk = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int at, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
        ev_t e;
        e.at = at; e.press = p; e.rel = r; e.lng = l;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Any pulse must match the oldest pending expectation exactly, in cycle and value.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n && ((kif.key_press | kif.key_release | kif.key_long) != 4'b0)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {20'b0, kif.key_press, kif.key_release, kif.key_long}, 32'b0);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.at);
                check("pulse_press", kif.key_press, e.press);
                check("pulse_release", kif.key_release, e.rel);
                check("pulse_long", kif.key_long, e.lng);
            end
        end
    end

    initial begin
        int c;
        int c2;
        kif.key_n = 4'b1111;
        rst_n = 1'b0;

        // Reset and idle
        step(3);
        check("rst_outputs", {16'b0, kif.key_level, kif.key_press, kif.key_release, kif.key_long}, 32'b0);
        step(7);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            check("idle_level", kif.key_level, 4'b0000);
        end

        // Clean press and release of key 0
        c = cyc;
        kif.key_n[0] = 1'b0;
        expect_ev(c + LAT, 4'b0001, 4'b0000, 4'b0000);
        step(LAT - 1);
        check("t2_level_early", kif.key_level, 4'b0000);
        step(1);
        check("t2_level", kif.key_level, 4'b0001);
        step(5);
        c = cyc;
        kif.key_n[0] = 1'b1;
        expect_ev(c + LAT, 4'b0000, 4'b0001, 4'b0000);
        step(LAT - 1);
        check("t2_rel_early", kif.key_level, 4'b0001);
        step(1);
        check("t2_rel_level", kif.key_level, 4'b0000);
        step(10);

        // Bouncing key 1, then a held press
        for (int i = 0; i < 40; i++) begin
            kif.key_n[1] = (((i / 3) % 2) != 0);
            step(1);
        end
        check("t3_bounce_level", kif.key_level, 4'b0000);
        c = cyc;
        kif.key_n[1] = 1'b0;
        expect_ev(c + LAT, 4'b0010, 4'b0000, 4'b0000);
        step(LAT);
        check("t3_level", kif.key_level, 4'b0010);
        step(5);
        c = cyc;
        kif.key_n[1] = 1'b1;
        expect_ev(c + LAT, 4'b0000, 4'b0010, 4'b0000);
        step(LAT + 10);
        check("t3_rel_level", kif.key_level, 4'b0000);

        // Keys 0 and 3 together
        c = cyc;
        kif.key_n = 4'b0110;
        expect_ev(c + LAT, 4'b1001, 4'b0000, 4'b0000);
        if (LP) expect_ev(c + LAT + LC, 4'b0000, 4'b0000, 4'b1001);
        step(50);
        check("t4_level", kif.key_level, 4'b1001);
        c2 = cyc;
        kif.key_n = 4'b1111;
        expect_ev(c2 + LAT, 4'b0000, 4'b1001, 4'b0000);
        step(LAT + 10);
        check("t4_rel_level", kif.key_level, 4'b0000);

        // Reset while key 2 is held, key still down after reset
        c = cyc;
        kif.key_n = 4'b1011;
        expect_ev(c + LAT, 4'b0100, 4'b0000, 4'b0000);
        step(15);
        check("t5_held_level", kif.key_level, 4'b0100);
        rst_n = 1'b0;
        #1;
        check("t5_rst_level", kif.key_level, 4'b0000);
        step(3);
        rst_n = 1'b1;
        c2 = cyc;
        expect_ev(c2 + LAT, 4'b0100, 4'b0000, 4'b0000);
        step(LAT - 1);
        check("t5_level_early", kif.key_level, 4'b0000);
        step(1);
        check("t5_level", kif.key_level, 4'b0100);
        step(5);
        c = cyc;
        kif.key_n = 4'b1111;
        expect_ev(c + LAT, 4'b0000, 4'b0100, 4'b0000);
        step(LAT + 10);
        check("t5_rel_level", kif.key_level, 4'b0000);

        // Long hold of key 0
        c = cyc;
        kif.key_n[0] = 1'b0;
        expect_ev(c + LAT, 4'b0001, 4'b0000, 4'b0000);
        if (LP) expect_ev(c + LAT + LC, 4'b0000, 4'b0000, 4'b0001);
        step(100);
        check("t6_level", kif.key_level, 4'b0001);
        c2 = cyc;
        kif.key_n[0] = 1'b1;
        expect_ev(c2 + LAT, 4'b0000, 4'b0001, 4'b0000);
        step(LAT + 10);
        check("t6_rel_level", kif.key_level, 4'b0000);

        for (int i = 0; i < 50 && sb.size() != 0; i++) step(1);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
